// File: rtl/rbm_stochastic_sampler_pkg.sv
// Shared definitions for the RBM stochastic sampler: FSM encoding, LFSR taps,
// per-channel seed derivation and packed-port slicing.
package rbm_stochastic_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_STRIDE = 16'h01D3;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] ch_seed(input logic [15:0] base, input int ch);
        logic [15:0] s;
        s = base + 16'(ch) * SEED_STRIDE;
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

`define RBM_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

// File: rtl/rbm_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable; the seed is
// also the reset value. Only the low OUT_W bits are exported.
module rbm_lfsr16
    import rbm_stochastic_sampler_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      seed_i,
    input  logic             load_i,
    input  logic             step_i,
    output logic [OUT_W-1:0] state_o
);

    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= seed_i;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/rbm_stochastic_sampler.sv
// Multi-channel Bernoulli sampler: each accepted beat compares every channel's
// probability against its own LFSR and accumulates the 0/1 result into a saturating count.
module rbm_stochastic_sampler
    import rbm_stochastic_sampler_pkg::*;
#(
    parameter int          N_CH            = 5,
    parameter int          SIG_W           = 8,
    parameter int          CNT_W           = 12,
    parameter int          ITER_W          = 16,
    parameter logic [15:0] SEED_BASE       = 16'hACE1,
    parameter bit          RESEED_ON_START = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ITER_W-1:0]     iter_target_i,
    input  logic                  prob_valid_i,
    output logic                  prob_ready_o,
    input  logic [N_CH*SIG_W-1:0] prob_i,
    output logic [N_CH-1:0]       sample_o,
    output logic                  sample_valid_o,
    output logic [N_CH*CNT_W-1:0] count_o,
    output logic                  busy_o,
    output logic                  done_o
);

    state_e            state_q, state_d;
    logic [ITER_W-1:0] iter_q, beats_q;
    logic [N_CH-1:0]   sample_q, samp;
    logic              sample_valid_q;
    logic              start_ok, accept, last_beat, lfsr_load;

    assign start_ok  = (state_q == ST_IDLE) && start_i;
    assign accept    = prob_valid_i && prob_ready_o;
    // iter_q is never zero while in RUN, so iter_q-1 cannot wrap there.
    assign last_beat = accept && (beats_q == iter_q - 1'b1);
    assign lfsr_load = start_ok && RESEED_ON_START;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (iter_target_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (last_beat) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prob_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            ST_RUN: begin
                busy_o       = 1'b1;
                prob_ready_o = ~abort_i;
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iter_q         <= '0;
            beats_q        <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= accept;
            if (accept) begin
                sample_q <= samp;
            end
            if (start_ok) begin
                iter_q  <= iter_target_i;
                beats_q <= '0;
            end else if (accept) begin
                beats_q <= beats_q + 1'b1;
            end
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SIG_W-1:0] p, r;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        assign p = `RBM_SLICE(prob_i, g, SIG_W);

        rbm_lfsr16 #(.OUT_W(SIG_W)) u_lfsr (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .seed_i  (ch_seed(SEED_BASE, g)),
            .load_i  (lfsr_load),
            .step_i  (accept),
            .state_o (r)
        );

        // All-ones probability means 1.0, which the strict compare alone cannot reach.
        assign samp[g] = (&p) | (r < p);

        always_comb begin
            cnt_d = cnt_q;
            if (start_ok) begin
                cnt_d = '0;
            end else if (accept && samp[g] && !(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign `RBM_SLICE(count_o, g, CNT_W) = cnt_q;
    end

endmodule

// File: tb/tb_rbm_stochastic_sampler.sv
// Bench for rbm_stochastic_sampler: three instances (default, 4-bit counts,
// free-running LFSRs) share stimulus and are checked against a beat-level model.
module tb_rbm_stochastic_sampler;

    localparam int NCH = 5;
    localparam int NI  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, abort, pvalid;
    logic [15:0] tgt;
    logic [39:0] probs;
    logic [NI-1:0] ready, busy, done, sv;
    logic [NI-1:0][4:0] samp;
    logic [59:0] cnt_main, cnt_nrs;
    logic [19:0] cnt_sat;

    rbm_stochastic_sampler u_main (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .iter_target_i(tgt),
        .prob_valid_i(pvalid), .prob_ready_o(ready[0]), .prob_i(probs), .sample_o(samp[0]),
        .sample_valid_o(sv[0]), .count_o(cnt_main), .busy_o(busy[0]), .done_o(done[0]));

    rbm_stochastic_sampler #(.CNT_W(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .iter_target_i(tgt),
        .prob_valid_i(pvalid), .prob_ready_o(ready[1]), .prob_i(probs), .sample_o(samp[1]),
        .sample_valid_o(sv[1]), .count_o(cnt_sat), .busy_o(busy[1]), .done_o(done[1]));

    rbm_stochastic_sampler #(.RESEED_ON_START(1'b0)) u_nrs (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .iter_target_i(tgt),
        .prob_valid_i(pvalid), .prob_ready_o(ready[2]), .prob_i(probs), .sample_o(samp[2]),
        .sample_valid_o(sv[2]), .count_o(cnt_nrs), .busy_o(busy[2]), .done_o(done[2]));

    // Reference model state (instance 1 has 4-bit counts, instance 2 never reseeds on start)
    logic [15:0] m_lfsr [NI][NCH];
    int          m_cnt  [NI][NCH];
    logic [4:0]  m_samp [NI];
    bit          m_run, e_done, e_sv;
    int          m_taken, m_target;

    int n_checks = 0;
    int n_fail = 0;
    int done_seen = 0;

    typedef struct {
        int          target;
        logic [39:0] probs;
        int          vmode;
        int          abort_at;
        int          exp_c0;
        int          exp_c1;
        int          exp_sat1;
        int          exp_done;
    } vec_t;

    vec_t vecs [6];

    function automatic int cmax(int k);
        return (k == 1) ? 15 : 4095;
    endfunction

    function automatic logic [15:0] seed_of(int c);
        int v;
        v = (32'hACE1 + c * 32'h01D3) % 65536;
        return (v == 0) ? 16'h0001 : 16'(v);
    endfunction

    function automatic logic [15:0] adv(logic [15:0] s);
        if (s[0]) return (s >> 1) ^ 16'hB400;
        return s >> 1;
    endfunction

    function automatic int dut_cnt(int k, int c);
        case (k)
            0:       return int'(cnt_main[c*12 +: 12]);
            1:       return int'(cnt_sat[c*4 +: 4]);
            default: return int'(cnt_nrs[c*12 +: 12]);
        endcase
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_samp[k] = '0;
            for (int c = 0; c < NCH; c++) begin
                m_lfsr[k][c] = seed_of(c);
                m_cnt[k][c]  = 0;
            end
        end
        m_run = 0; e_done = 0; e_sv = 0; m_taken = 0; m_target = 0;
    endtask

    // Advance the model by one clock edge given the inputs held across it.
    task automatic model_edge(bit st, bit ab, bit v, int t, logic [39:0] p);
        bit idle;
        int pc, r;
        bit s;
        idle = !m_run && !e_done;
        e_done = 0;
        e_sv = 0;
        if (idle && st) begin
            m_target = t;
            m_taken = 0;
            for (int k = 0; k < NI; k++)
                for (int c = 0; c < NCH; c++) begin
                    m_cnt[k][c] = 0;
                    if (k != 2) m_lfsr[k][c] = seed_of(c);
                end
            if (t == 0) e_done = 1;
            else m_run = 1;
        end else if (m_run && ab) begin
            m_run = 0;
        end else if (m_run && v) begin
            for (int k = 0; k < NI; k++)
                for (int c = 0; c < NCH; c++) begin
                    pc = int'(p[c*8 +: 8]);
                    r  = int'(m_lfsr[k][c] & 16'h00FF);
                    s  = (pc == 255) || (r < pc);
                    m_samp[k][c] = s;
                    if (s && m_cnt[k][c] < cmax(k)) m_cnt[k][c]++;
                    m_lfsr[k][c] = adv(m_lfsr[k][c]);
                end
            e_sv = 1;
            m_taken++;
            if (m_taken == m_target) begin
                m_run = 0;
                e_done = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("busy[%0d]", k), int'(busy[k]), int'(m_run));
            chk($sformatf("done[%0d]", k), int'(done[k]), int'(e_done));
            chk($sformatf("sample_valid[%0d]", k), int'(sv[k]), int'(e_sv));
            chk($sformatf("sample[%0d]", k), int'(samp[k]), int'(m_samp[k]));
            for (int c = 0; c < NCH; c++)
                chk($sformatf("count[%0d][%0d]", k, c), dut_cnt(k, c), m_cnt[k][c]);
        end
        if (done[0]) done_seen++;
    endtask

    task automatic step(bit st, bit ab, bit v, int t, logic [39:0] p);
        @(negedge clk);
        check_all();
        start = st; abort = ab; pvalid = v; tgt = 16'(t); probs = p;
        #1;
        for (int k = 0; k < NI; k++)
            chk($sformatf("prob_ready[%0d]", k), int'(ready[k]), int'(m_run && !ab));
        model_edge(st, ab, v, t, p);
    endtask

    task automatic check_zero(string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s ready[%0d]", tag, k), int'(ready[k]), 0);
            chk($sformatf("%s busy[%0d]", tag, k), int'(busy[k]), 0);
            chk($sformatf("%s done[%0d]", tag, k), int'(done[k]), 0);
            chk($sformatf("%s sample_valid[%0d]", tag, k), int'(sv[k]), 0);
            chk($sformatf("%s sample[%0d]", tag, k), int'(samp[k]), 0);
            for (int c = 0; c < NCH; c++)
                chk($sformatf("%s count[%0d][%0d]", tag, k, c), dut_cnt(k, c), 0);
        end
    endtask

    task automatic run_vec(int idx);
        vec_t v;
        int   cyc, d0;
        bit   val;
        v = vecs[idx];
        d0 = done_seen;
        step(1, 0, 0, v.target, v.probs);
        cyc = 0;
        while ((m_run || e_done) && cyc < 500) begin
            case (v.vmode)
                0:       val = 1;
                1:       val = (cyc % 3 == 0);
                default: val = 1'($urandom_range(0, 1));
            endcase
            // iter_target is deliberately disturbed during the run
            step(0, (v.abort_at >= 0) && (m_taken == v.abort_at), val, v.target + 7, v.probs);
            cyc++;
        end
        if (cyc >= 500) begin
            n_checks++; n_fail++;
            $display("FAIL vec%0d cycle budget exhausted", idx);
        end
        step(0, 0, 0, 0, v.probs);
        chk($sformatf("vec%0d count0", idx), dut_cnt(0, 0), v.exp_c0);
        chk($sformatf("vec%0d count1", idx), dut_cnt(0, 1), v.exp_c1);
        chk($sformatf("vec%0d sat count1", idx), dut_cnt(1, 1), v.exp_sat1);
        chk($sformatf("vec%0d done pulses", idx), done_seen - d0, v.exp_done);
    endtask

    function automatic logic [39:0] rand_probs();
        logic [39:0] p;
        for (int c = 0; c < NCH; c++) begin
            case ($urandom_range(0, 3))
                0:       p[c*8 +: 8] = 8'h00;
                1:       p[c*8 +: 8] = 8'hFF;
                default: p[c*8 +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return p;
    endfunction

    initial begin
        //           target probs            vmode abort c0  c1   sat1 done
        vecs[0] = '{100, 40'h808080FF00, 0, -1,  0, 100, 15, 1};
        vecs[1] = '{10,  40'h808080FF00, 1, -1,  0, 10,  10, 1};
        vecs[2] = '{20,  40'hFFFFFFFFFF, 0, -1,  20, 20, 15, 1};
        vecs[3] = '{10,  40'hFFFFFFFFFF, 0,  5,  5,  5,  5,  0};
        vecs[4] = '{0,   40'h808080FF00, 0, -1,  0,  0,  0,  1};
        vecs[5] = '{10,  40'h808080FF00, 0, -1,  0, 10,  10, 1};

        start = 0; abort = 0; pvalid = 0; tgt = '0; probs = '0;
        model_reset();
        #2;
        check_zero("reset");
        #10 rst_n = 1'b1;
        step(0, 0, 0, 0, '0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Asynchronous reset in the middle of a run, then a fresh run from the seeds
        step(1, 0, 0, 10, 40'h808080FF00);
        repeat (3) step(0, 0, 1, 10, 40'h808080FF00);
        @(negedge clk);
        #2 rst_n = 1'b0;
        start = 0; abort = 0; pvalid = 0;
        #1;
        check_zero("midrun reset");
        model_reset();
        #3 rst_n = 1'b1;
        run_vec(1);

        // Randomized traffic: starts anywhere, aborts, gaps, random probabilities
        repeat (800) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), rand_probs());
        end
        repeat (3) step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
